// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle logic/arith ops plus a shift-add multiplier
// that runs DATA_W iterations behind a start/busy/done handshake.
module alu_multicycle #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [3:0]        ctrl_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [0:0] {StIdle, StMul} state_e;

    localparam logic [3:0] CtrlAnd = 4'd0;
    localparam logic [3:0] CtrlOr  = 4'd1;
    localparam logic [3:0] CtrlAdd = 4'd2;
    localparam logic [3:0] CtrlMul = 4'd3;
    localparam logic [3:0] CtrlSub = 4'd6;
    localparam logic [3:0] CtrlSlt = 4'd7;

    state_e            r_state;
    logic [DATA_W-1:0] r_result;
    logic              r_done;
    logic              r_busy;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_mcand;
    logic [DATA_W-1:0] r_mplier;
    logic [CNT_W-1:0]  r_cnt;

    logic [DATA_W-1:0] w_alu;
    logic [DATA_W-1:0] w_acc_sum;
    logic              w_slt;
    logic              w_last;

    // Single-cycle result straight from the live operands (used only on the accept edge)
    always_comb begin
        w_alu = '0;
        w_slt = $signed(src1_i) < $signed(src2_i);
        case (ctrl_i)
            CtrlAnd: w_alu = src1_i & src2_i;
            CtrlOr:  w_alu = src1_i | src2_i;
            CtrlAdd: w_alu = src1_i + src2_i;
            CtrlSub: w_alu = src1_i - src2_i;
            CtrlSlt: w_alu = {{(DATA_W-1){1'b0}}, w_slt};
            default: w_alu = '0;
        endcase
    end

    // One shift-add step: add the shifted multiplicand when the multiplier LSB is set
    always_comb begin
        w_acc_sum = r_acc + (r_mplier[0] ? r_mcand : '0);
        w_last    = (r_cnt == CNT_W'(DATA_W - 1));
    end

    // Control FSM with registered result/busy/done
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= StIdle;
            r_result <= '0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (start_i) begin
                        if (ctrl_i == CtrlMul) begin
                            r_state  <= StMul;
                            r_busy   <= 1'b1;
                            r_acc    <= '0;
                            r_mcand  <= src1_i;
                            r_mplier <= src2_i;
                            r_cnt    <= '0;
                        end else begin
                            r_result <= w_alu;
                            r_done   <= 1'b1;
                        end
                    end
                end
                StMul: begin
                    r_acc    <= w_acc_sum;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_result <= w_acc_sum;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign result_o = r_result;
    assign zero_o   = (r_result == '0);
    assign busy_o   = r_busy;
    assign done_o   = r_done;

endmodule

// File: tb/tb_alu_multicycle.sv
// Randomised and directed self-checking bench for alu_multicycle.
module tb_alu_multicycle;

    localparam int unsigned DW = 32;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic [3:0]    ctrl_i;
    logic [DW-1:0] src1_i;
    logic [DW-1:0] src2_i;
    logic [DW-1:0] result_o;
    logic          zero_o;
    logic          busy_o;
    logic          done_o;

    int n_total = 0;
    int n_bad   = 0;

    alu_multicycle #(.DATA_W(DW), .CNT_W(6)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .ctrl_i   (ctrl_i),
        .src1_i   (src1_i),
        .src2_i   (src2_i),
        .result_o (result_o),
        .zero_o   (zero_o),
        .busy_o   (busy_o),
        .done_o   (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference behaviour computed directly from the op definitions
    function automatic logic [DW-1:0] ref_op(input logic [3:0] c, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
        longint unsigned p;
        case (c)
            4'd0: return a & b;
            4'd1: return a | b;
            4'd2: return DW'(a + b);
            4'd3: begin
                p = longint'(a) * longint'(b);
                return p[DW-1:0];
            end
            4'd6: return DW'(a - b);
            4'd7: return ($signed(a) < $signed(b)) ? 1 : 0;
            default: return '0;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    // Issue one op, wait for completion within a bound, check latency/result/pulse
    task automatic run_op(input string tag, input logic [3:0] c, input logic [DW-1:0] a,
                          input logic [DW-1:0] b);
        logic [DW-1:0] exp;
        int n;
        exp     = ref_op(c, a, b);
        start_i = 1'b1;
        ctrl_i  = c;
        src1_i  = a;
        src2_i  = b;
        tick();
        start_i = 1'b0;
        src1_i  = $urandom;
        src2_i  = $urandom;
        n = 0;
        while (busy_o && n < 100) begin
            if (done_o) check({tag, " done_during_busy"}, 64'(done_o), 64'd0);
            n++;
            tick();
        end
        check({tag, " busy_cycles"}, 64'(n), (c == 4'd3) ? 64'(DW) : 64'd0);
        check({tag, " done"}, 64'(done_o), 64'd1);
        check({tag, " result"}, 64'(result_o), 64'(exp));
        check({tag, " zero"}, 64'(zero_o), 64'(exp == '0));
        tick();
        check({tag, " done_single"}, 64'(done_o), 64'd0);
        check({tag, " hold"}, 64'(result_o), 64'(exp));
    endtask

    initial begin
        int n;
        int dones;
        logic saw_two;
        logic [3:0] legal [6];
        logic [3:0] c;
        legal = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7};

        rst_i   = 1'b1;
        start_i = 1'b0;
        ctrl_i  = 4'd0;
        src1_i  = '0;
        src2_i  = '0;
        #12;
        check("rst result", 64'(result_o), 64'd0);
        check("rst zero", 64'(zero_o), 64'd1);
        check("rst busy", 64'(busy_o), 64'd0);
        check("rst done", 64'(done_o), 64'd0);
        rst_i = 1'b0;
        tick();

        run_op("add5_7", 4'd2, 32'd5, 32'd7);
        run_op("sub3_3", 4'd6, 32'd3, 32'd3);
        run_op("slt_neg", 4'd7, 32'hFFFF_FFFF, 32'd1);
        run_op("slt_pos", 4'd7, 32'd1, 32'hFFFF_FFFF);
        run_op("add_wrap", 4'd2, 32'hFFFF_FFFF, 32'd1);
        run_op("mul_m1x3", 4'd3, 32'hFFFF_FFFF, 32'd3);
        run_op("mul_ovf", 4'd3, 32'h1_0000, 32'h1_0000);
        run_op("illegal9", 4'd9, 32'h1234, 32'h5678);

        // Idle: no start, result must hold and no done
        tick();
        tick();
        check("idle hold", 64'(result_o), 64'd0);
        check("idle done", 64'(done_o), 64'd0);

        // start while busy is ignored; operand change mid-flight has no effect
        start_i = 1'b1;
        ctrl_i  = 4'd3;
        src1_i  = 32'd6;
        src2_i  = 32'd7;
        tick();
        start_i = 1'b0;
        n = 0;
        dones = 0;
        saw_two = 1'b0;
        while (busy_o && n < 100) begin
            if (n == 9) begin
                start_i = 1'b1;
                ctrl_i  = 4'd2;
                src1_i  = 32'd1;
                src2_i  = 32'd1;
            end else if (n == 10) begin
                start_i = 1'b0;
                src1_i  = 32'd100;
            end
            if (result_o == 32'd2) saw_two = 1'b1;
            if (done_o) dones++;
            n++;
            tick();
        end
        check("ign busy_cycles", 64'(n), 64'(DW));
        check("ign result", 64'(result_o), 64'd42);
        for (int i = 0; i < 3; i++) begin
            if (done_o) dones++;
            if (result_o == 32'd2) saw_two = 1'b1;
            tick();
        end
        check("ign done_count", 64'(dones), 64'd1);
        check("ign no_add", 64'(saw_two), 64'd0);

        // Reset mid-MUL aborts with no done
        start_i = 1'b1;
        ctrl_i  = 4'd3;
        src1_i  = 32'd9;
        src2_i  = 32'd9;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        rst_i = 1'b1;
        #2;
        check("abort result", 64'(result_o), 64'd0);
        check("abort busy", 64'(busy_o), 64'd0);
        check("abort done", 64'(done_o), 64'd0);
        tick();
        rst_i = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (done_o || busy_o) dones++;
            tick();
        end
        check("abort quiet", 64'(dones), 64'd0);
        run_op("and", 4'd0, 32'h0000_F0F0, 32'h0000_FF00);

        // Back-to-back: OR request held through the MUL done cycle
        start_i = 1'b1;
        ctrl_i  = 4'd3;
        src1_i  = 32'd2;
        src2_i  = 32'd3;
        tick();
        ctrl_i = 4'd1;
        src1_i = 32'd1;
        src2_i = 32'd2;
        n = 0;
        while (busy_o && n < 100) begin
            n++;
            tick();
        end
        check("b2b busy_cycles", 64'(n), 64'(DW));
        check("b2b mul done", 64'(done_o), 64'd1);
        check("b2b mul result", 64'(result_o), 64'd6);
        tick();
        start_i = 1'b0;
        check("b2b or done", 64'(done_o), 64'd1);
        check("b2b or result", 64'(result_o), 64'd3);
        check("b2b or busy", 64'(busy_o), 64'd0);
        tick();
        check("b2b done_low", 64'(done_o), 64'd0);

        // Randomised ops, occasionally illegal codes and corner operands
        for (int i = 0; i < 40; i++) begin
            logic [DW-1:0] a;
            logic [DW-1:0] b;
            c = legal[$urandom_range(0, 5)];
            if ($urandom_range(0, 7) == 0) c = 4'($urandom_range(8, 15));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = a;
            if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
            run_op($sformatf("rnd%0d_c%0d", i, c), c, a, b);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
